fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
Forwarding and hazard controller for the 16-bit pipelined datapath. It compares ID-stage source registers against in-flight EX/MEM destinations and produces registered 2-bit select codes for the two EX-stage operand forwarding muxes. It also stalls on load-use hazards and on multi-cycle multiplies, and inserts EX bubbles where required.
Mux select encoding:
- 00 = register file data
- 01 = ALU result high half [31:16]
- 10 = ALU result low half [15:0]
- 11 = WB data

Parameters:
MUL_LAT, 4, EX-stage occupancy of a multiply in cycles; legal range 1..16.
HI_REG, 15, architectural register that receives the upper 16 bits of a multiply result.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  4  ID source register 1
id_rs2  in  4  ID source register 2
ex_valid  in  1  EX stage holds a real instruction
ex_rd  in  4  EX destination register
ex_wr  in  1  EX instruction writes ex_rd
ex_is_load  in  1  EX instruction is a load
ex_is_mul  in  1  EX instruction is a multiply (low half to ex_rd, high half to HI_REG)
mem_valid  in  1  MEM stage holds a real instruction
mem_rd  in  4  MEM destination register
mem_wr  in  1  MEM instruction writes mem_rd
op1_src  out  2  operand-1 forwarding select, registered
op2_src  out  2  operand-2 forwarding select, registered
ex_bubble  out  1  EX pipeline register loads a NOP next cycle, registered
stall  out  1  freeze PC and IF/ID, combinational
mul_busy  out  1  multiply FSM in BUSY state

Behaviour:
Clock and reset:
- One clock (clk). Reset rst is asynchronous and active-high.
- On reset: op1_src=00, op2_src=00, ex_bubble=0, FSM=IDLE, counter=0, mul_busy=0. stall is forced to 0 while rst is high.
- Reset mid-multiply aborts the multiply and returns to IDLE.

Select computation (per source rs, evaluated in ID):
Priority, first match wins:
1. ex_valid & ex_wr & !ex_is_load & rs==ex_rd -> 10
2. ex_valid & ex_is_mul & rs==HI_REG -> 01
3. mem_valid & mem_wr & rs==mem_rd -> 11
4. Otherwise -> 00 (the register file is write-before-read).
If ex_rd==HI_REG on a multiply, rule 1 (10) wins.

Load-use hazard:
- Condition: id_valid & ex_valid & ex_is_load & ex_wr & (id_rs1==ex_rd | id_rs2==ex_rd).
- Response: stall=1 for exactly one cycle. On that edge op*_src load 00 and ex_bubble loads 1.
- The next cycle re-evaluates. The load is now in MEM, so the matching source gets 11.

Multiply FSM:
- IDLE:
  - If ex_valid & ex_is_mul & MUL_LAT>1: stall=1, go to BUSY, counter = MUL_LAT-2.
  - Otherwise no multiply stall.
- BUSY:
  - counter!=0: stall=1, counter decrements.
  - counter==0: stall=0, return to IDLE (the multiply leaves EX).
- Net effect: stall is high for MUL_LAT-1 consecutive cycles, and the multiply occupies EX for MUL_LAT cycles.
- MUL_LAT=1: never stalls.
- A multiply arriving in EX directly behind a multiply restarts the FSM from IDLE.

Register update each edge, priority order:
1. Multiply stall: hold op*_src; ex_bubble=0.
2. Load-use stall: op*_src=00; ex_bubble=1.
3. Otherwise: op*_src = computed selects; ex_bubble=0.

Misc:
- id_valid=0 -> selects computed as 00; no load-use stall is raised.
- Load-use and multiply stall cannot coexist, because EX holds one instruction. Multiply takes priority regardless.

Optional Feature:
Macro STALL_CNT_EN.
- Defined: adds output port stall_cycles[15:0]. It increments on every cycle stall=1, saturates at 16'hFFFF, and clears on rst.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Back-to-back ALU: EX writes r3, ID reads rs1=r3 -> op1_src=10 next cycle, stall=0.
2. Load-use: EX load to r5, ID rs2=r5 -> stall=1 for one cycle, then ex_bubble=1 and op2_src=00. The following edge gives op2_src=11.
3. Multiply, MUL_LAT=4: ex_is_mul, ex_rd=r2 -> stall high exactly 3 cycles, mul_busy high 3 cycles, op*_src held. At release, an ID read of r15 gives 01 and a read of r2 gives 10.
4. Priority: EX ALU writes r7 and MEM writes r7, ID reads r7 -> 10. EX not writing r7 -> 11. Neither writes r7 -> 00.
5. Reset mid-multiply: rst asserted on the 2nd stall cycle -> stall=0 and all outputs 0 immediately, without waiting for a clock edge. After release, FSM is in IDLE.
6. STALL_CNT_EN defined: run scenario 2 and then scenario 3 -> stall_cycles=4. Force 70000 stall cycles -> stall_cycles=16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-to-controller bundle for fwd_hazard_ctrl: ID/EX/MEM hazard inputs
// plus forwarding selects, bubble, stall and multiply-busy outputs.
interface fwd_hazard_ctrl_if;
  logic       id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       ex_valid;
  logic [3:0] ex_rd;
  logic       ex_wr;
  logic       ex_is_load;
  logic       ex_is_mul;
  logic       mem_valid;
  logic [3:0] mem_rd;
  logic       mem_wr;
  logic [1:0] op1_src;
  logic [1:0] op2_src;
  logic       ex_bubble;
  logic       stall;
  logic       mul_busy;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output ex_valid, ex_rd, ex_wr, ex_is_load, ex_is_mul,
    output mem_valid, mem_rd, mem_wr,
    input  op1_src, op2_src, ex_bubble, stall, mul_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  ex_valid, ex_rd, ex_wr, ex_is_load, ex_is_mul,
    input  mem_valid, mem_rd, mem_wr,
    output op1_src, op2_src, ex_bubble, stall, mul_busy
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: registered operand selects, load-use and multiply stalls.
// Optional macro STALL_CNT_EN adds a saturating stall_cycles counter port.
module fwd_hazard_ctrl #(
  parameter int         MUL_LAT = 4,
  parameter logic [3:0] HI_REG  = 4'd15
) (
  input  logic              clk,
  input  logic              rst,
`ifdef STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  fwd_hazard_ctrl_if.slave  bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam bit         MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] CNT_INIT  = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_op1_src;
  logic [1:0] r_op2_src;
  logic       r_ex_bubble;

  logic [3:0] w_rs  [2];
  logic [1:0] w_sel [2];
  logic       w_mul_start;
  logic       w_mul_stall;
  logic       w_lu_stall;

  assign w_rs[0] = bus.id_rs1;
  assign w_rs[1] = bus.id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_sel
      logic w_hit_ex;
      logic w_hit_hi;
      logic w_hit_mem;
      // Loads are excluded from EX forwarding: their data is not ready until MEM.
      assign w_hit_ex  = bus.ex_valid & bus.ex_wr & ~bus.ex_is_load & (w_rs[gi] == bus.ex_rd);
      assign w_hit_hi  = bus.ex_valid & bus.ex_is_mul & (w_rs[gi] == HI_REG);
      assign w_hit_mem = bus.mem_valid & bus.mem_wr & (w_rs[gi] == bus.mem_rd);
      assign w_sel[gi] = ~bus.id_valid ? 2'b00 :
                         w_hit_ex      ? 2'b10 :
                         w_hit_hi      ? 2'b01 :
                         w_hit_mem     ? 2'b11 : 2'b00;
    end
  endgenerate

  assign w_mul_start = bus.ex_valid & bus.ex_is_mul & MUL_MULTI;
  assign w_mul_stall = (r_state == S_IDLE) ? w_mul_start : (r_cnt != 4'd0);
  assign w_lu_stall  = bus.id_valid & bus.ex_valid & bus.ex_is_load & bus.ex_wr &
                       ((bus.id_rs1 == bus.ex_rd) | (bus.id_rs2 == bus.ex_rd));

  assign bus.stall     = ~rst & (w_mul_stall | w_lu_stall);
  assign bus.mul_busy  = (r_state == S_BUSY);
  assign bus.op1_src   = r_op1_src;
  assign bus.op2_src   = r_op2_src;
  assign bus.ex_bubble = r_ex_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_op1_src   <= 2'b00;
      r_op2_src   <= 2'b00;
      r_ex_bubble <= 1'b0;
    end else begin
      if (w_mul_stall) begin
        r_ex_bubble <= 1'b0;
      end else if (w_lu_stall) begin
        r_op1_src   <= 2'b00;
        r_op2_src   <= 2'b00;
        r_ex_bubble <= 1'b1;
      end else begin
        r_op1_src   <= w_sel[0];
        r_op2_src   <= w_sel[1];
        r_ex_bubble <= 1'b0;
      end

      // The release cycle (count 0) ignores EX so a trailing multiply restarts from IDLE.
      case (r_state)
        S_IDLE: begin
          if (w_mul_start) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_INIT;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
    end else if (bus.stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed plus randomized bench for fwd_hazard_ctrl against a cycle-count reference model.
module tb_fwd_hazard_ctrl;
  localparam int         MUL_LAT = 4;
  localparam logic [3:0] HI_REG  = 4'd15;

  logic clk;
  logic rst;
  fwd_hazard_ctrl_if bus();
`ifdef STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  fwd_hazard_ctrl #(.MUL_LAT(MUL_LAT), .HI_REG(HI_REG)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // Reference model: occ counts cycles the current multiply has already spent in EX.
  int         occ;
  logic [1:0] m_op1, m_op2;
  logic       m_bub;
  int         m_scnt;
  logic       obs_stall, obs_busy;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    occ = 0; m_op1 = 2'b00; m_op2 = 2'b00; m_bub = 1'b0; m_scnt = 0;
  endtask

  function automatic logic [1:0] ref_sel(input logic [3:0] rs);
    if (!bus.id_valid) return 2'b00;
    if (bus.ex_valid && bus.ex_wr && !bus.ex_is_load && rs == bus.ex_rd) return 2'b10;
    if (bus.ex_valid && bus.ex_is_mul && rs == HI_REG) return 2'b01;
    if (bus.mem_valid && bus.mem_wr && rs == bus.mem_rd) return 2'b11;
    return 2'b00;
  endfunction

  // One clock of stimulus, called at a falling edge.
  task automatic step(input logic idv, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic exv, input logic [3:0] exrd, input logic exwr,
                      input logic exld, input logic exmul,
                      input logic memv, input logic [3:0] memrd, input logic memwr);
    logic m_mul, m_lu, m_stall;
    logic [1:0] n_op1, n_op2;
    logic n_bub;
    bus.id_valid = idv; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.ex_valid = exv; bus.ex_rd = exrd; bus.ex_wr = exwr;
    bus.ex_is_load = exld; bus.ex_is_mul = exmul;
    bus.mem_valid = memv; bus.mem_rd = memrd; bus.mem_wr = memwr;
    #1;
    m_mul   = (occ == 0) ? (exv && exmul && MUL_LAT > 1) : (occ < MUL_LAT - 1);
    m_lu    = idv && exv && exld && exwr && (rs1 == exrd || rs2 == exrd);
    m_stall = m_mul || m_lu;
    check("stall", 16'(bus.stall), 16'(m_stall));
    check("mul_busy", 16'(bus.mul_busy), 16'(occ > 0));
    obs_stall = bus.stall;
    obs_busy  = bus.mul_busy;
    if (m_mul) begin
      n_op1 = m_op1; n_op2 = m_op2; n_bub = 1'b0;
    end else if (m_lu) begin
      n_op1 = 2'b00; n_op2 = 2'b00; n_bub = 1'b1;
    end else begin
      n_op1 = ref_sel(rs1); n_op2 = ref_sel(rs2); n_bub = 1'b0;
    end
    @(posedge clk);
    m_op1 = n_op1; m_op2 = n_op2; m_bub = n_bub;
    if (m_stall && m_scnt < 65535) m_scnt++;
    if (occ > 0 || (exv && exmul)) begin
      occ++;
      if (occ >= MUL_LAT) occ = 0;
    end
    @(negedge clk);
    check("op1_src", 16'(bus.op1_src), 16'(m_op1));
    check("op2_src", 16'(bus.op2_src), 16'(m_op2));
    check("ex_bubble", 16'(bus.ex_bubble), 16'(m_bub));
`ifdef STALL_CNT_EN
    check("stall_cycles", stall_cycles, 16'(m_scnt));
`endif
    step_no++;
    $display("step %0d: id=%b r%0d r%0d ex=%b r%0d w%b l%b m%b mem=%b r%0d w%b -> stall=%b op1=%b op2=%b bub=%b busy=%b",
             step_no, idv, rs1, rs2, exv, exrd, exwr, exld, exmul, memv, memrd, memwr,
             obs_stall, bus.op1_src, bus.op2_src, bus.ex_bubble, obs_busy);
  endtask

  function automatic logic [3:0] pick_reg();
    case ($urandom_range(0, 7))
      0: return 4'd2;
      1: return 4'd3;
      2: return 4'd5;
      3: return 4'd7;
      4: return HI_REG;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int stall_cnt, busy_cnt, kind;
    rst = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs1 = 4'd5; bus.id_rs2 = 4'd5;
    bus.ex_valid = 1'b1; bus.ex_rd = 4'd5; bus.ex_wr = 1'b1;
    bus.ex_is_load = 1'b1; bus.ex_is_mul = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_rd = 4'd0; bus.mem_wr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Load-use condition is present but reset must mask the stall.
    check("rst_stall", 16'(bus.stall), 16'd0);
    check("rst_op1", 16'(bus.op1_src), 16'd0);
    check("rst_op2", 16'(bus.op2_src), 16'd0);
    check("rst_bubble", 16'(bus.ex_bubble), 16'd0);
    check("rst_busy", 16'(bus.mul_busy), 16'd0);
`ifdef STALL_CNT_EN
    check("rst_stall_cycles", stall_cycles, 16'd0);
`endif
    rst = 1'b0;

    // Load-use: one stall, bubble with zero selects, then MEM forward.
    step(1, 4'd1, 4'd5, 1, 4'd5, 1, 1, 0, 0, 4'd0, 0);
    check("lu_stall", 16'(obs_stall), 16'd1);
    check("lu_bubble", 16'(bus.ex_bubble), 16'd1);
    check("lu_op2", 16'(bus.op2_src), 16'd0);
    step(1, 4'd1, 4'd5, 0, 4'd0, 0, 0, 0, 1, 4'd5, 1);
    check("lu_release_stall", 16'(obs_stall), 16'd0);
    check("lu_op2_mem", 16'(bus.op2_src), 16'd3);

    // Multiply: preload distinct selects, then verify hold and release values.
    step(1, 4'd3, 4'd4, 1, 4'd3, 1, 0, 0, 1, 4'd4, 1);
    stall_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < MUL_LAT; k++) begin
      step(1, HI_REG, 4'd2, 1, 4'd2, 1, 0, 1, 0, 4'd0, 0);
      stall_cnt += int'(obs_stall);
      busy_cnt  += int'(obs_busy);
      if (k < MUL_LAT - 1) begin
        check("mul_hold_op1", 16'(bus.op1_src), 16'd2);
        check("mul_hold_op2", 16'(bus.op2_src), 16'd3);
      end
    end
    check("mul_stall_count", 16'(stall_cnt), 16'd3);
    check("mul_busy_count", 16'(busy_cnt), 16'd3);
    check("mul_rel_op1_hi", 16'(bus.op1_src), 16'd1);
    check("mul_rel_op2_lo", 16'(bus.op2_src), 16'd2);
`ifdef STALL_CNT_EN
    check("stall_cycles_4", stall_cycles, 16'd4);
`endif

    // Back-to-back ALU forward.
    step(1, 4'd3, 4'd0, 1, 4'd3, 1, 0, 0, 0, 4'd0, 0);
    check("alu_stall", 16'(obs_stall), 16'd0);
    check("alu_op1", 16'(bus.op1_src), 16'd2);

    // Priority EX over MEM, MEM alone, neither.
    step(1, 4'd7, 4'd7, 1, 4'd7, 1, 0, 0, 1, 4'd7, 1);
    check("prio_ex", 16'(bus.op1_src), 16'd2);
    step(1, 4'd7, 4'd7, 1, 4'd6, 1, 0, 0, 1, 4'd7, 1);
    check("prio_mem", 16'(bus.op1_src), 16'd3);
    step(1, 4'd7, 4'd7, 1, 4'd6, 1, 0, 0, 1, 4'd8, 1);
    check("prio_none", 16'(bus.op1_src), 16'd0);
    step(0, 4'd7, 4'd7, 1, 4'd7, 1, 0, 0, 1, 4'd7, 1);
    check("id_invalid", 16'(bus.op2_src), 16'd0);

    // Two multiplies back to back: each stalls MUL_LAT-1 cycles.
    stall_cnt = 0;
    for (int k = 0; k < 2 * MUL_LAT; k++) begin
      step(1, 4'd1, 4'd2, 1, 4'd9, 1, 0, 1, 0, 4'd0, 0);
      stall_cnt += int'(obs_stall);
    end
    check("mul_b2b_stalls", 16'(stall_cnt), 16'd6);

    // Reset asserted on the second stall cycle of a multiply.
    step(1, 4'd3, 4'd4, 1, 4'd3, 1, 0, 0, 1, 4'd4, 1);
    step(1, 4'd1, 4'd2, 1, 4'd2, 1, 0, 1, 0, 4'd0, 0);
    check("pre_rst_stall", 16'(bus.stall), 16'd1);
    rst = 1'b1;
    #1;
    check("arst_stall", 16'(bus.stall), 16'd0);
    check("arst_op1", 16'(bus.op1_src), 16'd0);
    check("arst_op2", 16'(bus.op2_src), 16'd0);
    check("arst_busy", 16'(bus.mul_busy), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 4'd1, 4'd2, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0);
    check("post_rst_idle", 16'(obs_stall), 16'd0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 7);
      step(($urandom_range(0, 9) != 0), pick_reg(), pick_reg(),
           (kind != 0), pick_reg(), ($urandom_range(0, 3) != 0),
           (kind == 5 || kind == 6), (kind == 7),
           ($urandom_range(0, 3) != 0), pick_reg(), ($urandom_range(0, 3) != 0));
    end

`ifdef STALL_CNT_EN
    bus.id_valid = 1'b1; bus.id_rs1 = 4'd5; bus.ex_valid = 1'b1; bus.ex_rd = 4'd5;
    bus.ex_wr = 1'b1; bus.ex_is_load = 1'b1; bus.ex_is_mul = 1'b0;
    for (int n = 0; n < 70000; n++) @(posedge clk);
    @(negedge clk);
    check("stall_cycles_sat", stall_cycles, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
